// File: rtl/sha_host_mem.sv
// Host-side message/digest buffer for a SHA-256 core: loads message words from a stream,
// kicks the core, services its memory port and streams the 8-word digest back out.
module sha_host_mem #(
  parameter int unsigned NUM_OF_WORDS = 20,
  parameter int unsigned DEPTH        = 64,
  parameter logic [15:0] MSG_BASE     = 16'd0,
  parameter logic [15:0] OUT_BASE     = 16'd32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic [31:0] core_mem_read_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(NUM_OF_WORDS + 1);

  typedef enum logic [2:0] {StLoad, StKick, StWaitLow, StWaitDone, StDrain} state_e;

  state_e        state;
  logic [CW-1:0] load_cnt;
  logic [2:0]    drain_idx;
  logic [31:0]   mem [DEPTH];

  logic          core_in_range;
  logic          core_wr_window;
  logic          host_we;
  logic          core_we_ok;
  logic [AW-1:0] host_idx;
  logic [AW-1:0] out_idx;
  logic [AW-1:0] core_idx;

  assign core_in_range  = 32'(core_mem_addr) < DEPTH;
  assign core_idx       = core_mem_addr[AW-1:0];
  assign host_idx       = AW'(MSG_BASE) + AW'(load_cnt);
  assign out_idx        = AW'(OUT_BASE) + AW'(drain_idx);
  assign core_wr_window = (state == StWaitLow) || (state == StWaitDone);
  assign host_we        = (state == StLoad) && in_valid && in_ready;
  assign core_we_ok     = core_mem_we && core_in_range && core_wr_window;

  assign out_data          = mem[out_idx];
  assign core_message_addr = MSG_BASE;
  assign core_output_addr  = OUT_BASE;

  // Host and core write windows are disjoint states, so one port suffices.
  always_ff @(posedge clk) begin
    if (host_we) begin
      mem[host_idx] <= in_data;
    end else if (core_we_ok) begin
      mem[core_idx] <= core_mem_write_data;
    end
  end

  // Read-before-write falls out of the non-blocking update of mem above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_mem_read_data <= '0;
      err                <= 1'b0;
    end else begin
      core_mem_read_data <= core_in_range ? mem[core_idx] : 32'h0;
      if (!core_in_range || (core_mem_we && !core_wr_window)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StLoad;
      load_cnt   <= '0;
      drain_idx  <= '0;
      in_ready   <= 1'b1;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        StLoad: begin
          if (host_we) begin
            load_cnt <= load_cnt + 1'b1;
            if (32'(load_cnt) + 32'd1 >= NUM_OF_WORDS) begin
              in_ready <= 1'b0;
            end
          end
          if (32'(load_cnt) >= NUM_OF_WORDS) begin
            state      <= StKick;
            core_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StKick: begin
          core_start <= 1'b0;
          state      <= StWaitLow;
        end
        // A stale high done level from the previous job must not count as completion.
        StWaitLow: begin
          if (!core_done) begin
            state <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (core_done) begin
            state     <= StDrain;
            drain_idx <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        StDrain: begin
          if (out_ready) begin
            drain_idx <= drain_idx + 1'b1;
            out_last  <= (drain_idx == 3'd6);
            if (out_last) begin
              state     <= StLoad;
              load_cnt  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule
